// File: rtl/branch_defs.sv
// Shared definitions for the fetch/branch path: instruction IDs, link register,
// sequencer state encoding and control-instruction classification helpers.
package branch_defs;

    localparam int ID_BEQ  = 15;
    localparam int ID_BNE  = 16;
    localparam int ID_BGT  = 17;
    localparam int ID_BGTE = 18;
    localparam int ID_BLE  = 19;
    localparam int ID_BLEQ = 20;
    localparam int ID_J    = 21;
    localparam int ID_JR   = 22;
    localparam int ID_JAL  = 23;

    localparam int LINK_REG = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_RESOLVE,
        ST_HALT
    } state_t;

    function automatic logic is_cond_branch(input logic [31:0] id);
        return (id >= 32'(ID_BEQ)) && (id <= 32'(ID_BLEQ));
    endfunction

    function automatic logic is_jump(input logic [31:0] id);
        return (id >= 32'(ID_J)) && (id <= 32'(ID_JAL));
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC and jal link computation from the resolved instruction.
module pc_next_calc
    import branch_defs::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       res_id,
    input  logic [ADDR_W-1:0] res_offset,
    output logic [ADDR_W-1:0] next_pc,
    output logic              link_en,
    output logic [31:0]       link_data
);

    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc    = pc + ADDR_W'(1);
    assign link_data = {{(32-ADDR_W){1'b0}}, pc_inc};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        next_pc = pc_inc;
        link_en = 1'b0;
        if (is_cond_branch(res_id)) begin
            // Offset 0 (not taken) naturally falls back to pc+1; wrap is modulo 2^ADDR_W.
            next_pc = pc_inc + res_offset;
        end else if (is_jump(res_id)) begin
            next_pc = res_offset;
            link_en = (res_id == 32'(ID_JAL));
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: fetch, issue to decode, await branch resolution.
// Optional build macro TAKEN_CNT_EN enables the saturating taken-redirect counter.
module pc_sequencer
    import branch_defs::*;
#(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              res_valid,
    input  logic [31:0]       res_id,
    input  logic [31:0]       res_target,
    input  logic              halt,
    output logic              link_we,
    output logic [31:0]       link_data,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  taken_cnt
);

    state_t            state;
    logic [ADDR_W-1:0] calc_next_pc;
    logic              calc_link_en;
    logic [31:0]       calc_link_data;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
        .pc         (pc),
        .res_id     (res_id),
        .res_offset (res_target[ADDR_W-1:0]),
        .next_pc    (calc_next_pc),
        .link_en    (calc_link_en),
        .link_data  (calc_link_data)
    );

    assign imem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= ADDR_W'(RESET_PC);
            imem_req  <= 1'b0;
            ir_valid  <= 1'b0;
            ir_out    <= '0;
            link_we   <= 1'b0;
            link_data <= '0;
        end else begin
            link_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= halt ? ST_HALT : ST_FETCH;
                    imem_req <= ~halt;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        ir_out   <= imem_rdata;
                        ir_valid <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    if (res_valid) begin
                        pc       <= calc_next_pc;
                        link_we  <= calc_link_en;
                        if (calc_link_en) link_data <= calc_link_data;
                        state    <= halt ? ST_HALT : ST_FETCH;
                        imem_req <= ~halt;
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TAKEN_CNT_EN
    logic is_taken;

    assign is_taken = is_jump(res_id) || (is_cond_branch(res_id) && (res_target != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
        end else if (state == ST_RESOLVE && res_valid && is_taken && taken_cnt != '1) begin
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
    end
`else
    // Upper target bits only matter to the counter; tie them off here.
    logic unused_target_hi;

    assign unused_target_hi = &{1'b0, res_target[31:ADDR_W]};
    assign taken_cnt        = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus randomized instruction stream
// checked against a transaction-level PC/counter model.
module tb_pc_sequencer;

    localparam int AW  = 10;
    localparam int CW  = 16;
    localparam int MOD = 1 << AW;

`ifdef TAKEN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic [31:0]   ir_out;
    logic          ir_valid;
    logic          ir_ready;
    logic          res_valid;
    logic [31:0]   res_id;
    logic [31:0]   res_target;
    logic          halt;
    logic          link_we;
    logic [31:0]   link_data;
    logic [AW-1:0] pc;
    logic [CW-1:0] taken_cnt;

    int errors = 0;
    int checks = 0;
    int model_pc = 0;
    int model_cnt = 0;

    pc_sequencer #(.ADDR_W(AW), .RESET_PC(0), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_out     (ir_out),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_target (res_target),
        .halt       (halt),
        .link_we    (link_we),
        .link_data  (link_data),
        .pc         (pc),
        .taken_cnt  (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: PC arithmetic done on plain integers, then reduced mod 2^AW.
    function automatic int model_next(input int p, input int id, input logic [31:0] t);
        longint v;
        if (id >= 15 && id <= 20)      v = longint'(p) + 1 + longint'($signed(t));
        else if (id >= 21 && id <= 23) v = longint'(t);
        else                           v = longint'(p) + 1;
        return int'(((v % MOD) + MOD) % MOD);
    endfunction

    function automatic bit model_taken(input int id, input logic [31:0] t);
        return (id >= 21 && id <= 23) || (id >= 15 && id <= 20 && t != 0);
    endfunction

    task automatic wait_req;
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("req_wait", 64'(imem_req), 64'(1));
    endtask

    // One full fetch/issue/resolve transaction; h is held high from ISSUE through resolve.
    task automatic do_instr(input int ack_dly, input int rdy_dly, input int id,
                            input logic [31:0] tgt, input bit h);
        logic [31:0] word;
        int          nxt;
        word = $urandom;
        wait_req();
        chk("fetch_addr", 64'(imem_addr), 64'(model_pc));
        chk("pc_out", 64'(pc), 64'(model_pc));
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("req_hold", 64'(imem_req), 64'(1));
            chk("addr_hold", 64'(imem_addr), 64'(model_pc));
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        halt       = h;
        chk("ir_valid_set", 64'(ir_valid), 64'(1));
        chk("ir_out", 64'(ir_out), 64'(word));
        chk("req_drop", 64'(imem_req), 64'(0));
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            chk("ir_valid_hold", 64'(ir_valid), 64'(1));
            chk("ir_out_hold", 64'(ir_out), 64'(word));
        end
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        chk("ir_valid_drop", 64'(ir_valid), 64'(0));
        res_valid  = 1'b1;
        res_id     = 32'(id);
        res_target = tgt;
        tick();
        res_valid  = 1'b0;
        res_id     = $urandom;
        res_target = $urandom;
        nxt = model_next(model_pc, id, tgt);
        if (CNT_EN && model_taken(id, tgt) && model_cnt < (1 << CW) - 1) model_cnt++;
        chk("link_we", 64'(link_we), 64'(id == 23));
        if (id == 23) chk("link_data", 64'(link_data), 64'(model_pc + 1) % MOD);
        model_pc = nxt;
        chk("pc_next", 64'(pc), 64'(model_pc));
        chk("taken_cnt", 64'(taken_cnt), 64'(model_cnt));
        chk("req_after_res", 64'(imem_req), 64'(!h));
        if (id == 23) begin
            tick();
            chk("link_pulse_end", 64'(link_we), 64'(0));
        end
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ir_ready   = 1'b0;
        res_valid  = 1'b0;
        res_id     = '0;
        res_target = '0;
        halt       = 1'b1;
        #2;
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_ir_valid", 64'(ir_valid), 64'(0));
        chk("rst_ir_out", 64'(ir_out), 64'(0));
        chk("rst_link_we", 64'(link_we), 64'(0));
        chk("rst_pc", 64'(pc), 64'(0));
        chk("rst_cnt", 64'(taken_cnt), 64'(0));

        // Halt sampled in IDLE: no fetch until it drops.
        tick();
        reset = 1'b0;
        tick();
        chk("idle_halt_req", 64'(imem_req), 64'(0));
        tick();
        chk("idle_halt_hold", 64'(imem_req), 64'(0));
        halt = 1'b0;
        tick();
        chk("halt_release_req", 64'(imem_req), 64'(1));

        // Sequential fetch 0..4, then conditional taken / not taken.
        for (int i = 0; i < 4; i++) do_instr(0, 0, 1, $urandom, 1'b0);
        do_instr(0, 0, 16, 32'd2, 1'b0);
        chk("bne_target", 64'(model_pc), 64'(7));
        do_instr(0, 0, 15, 32'd0, 1'b0);
        chk("beq_nt_target", 64'(model_pc), 64'(8));

        // Jump to 10, jal to 100 with link 11.
        do_instr(0, 0, 21, 32'd10, 1'b0);
        do_instr(0, 0, 23, 32'd100, 1'b0);
        do_instr(0, 0, 22, 32'd1, 1'b0);

        // Negative offset wraps below zero; sequential wraps past the top.
        do_instr(0, 0, 17, 32'hFFFF_FFFC, 1'b0);
        chk("neg_wrap", 64'(model_pc), 64'(1022));
        do_instr(0, 0, 5, $urandom, 1'b0);
        do_instr(0, 0, 5, $urandom, 1'b0);
        chk("top_wrap", 64'(model_pc), 64'(0));

        // Slow memory and slow decode.
        do_instr(3, 2, 1, $urandom, 1'b0);

        // Randomized stream.
        for (int n = 0; n < 40; n++) begin
            int          id;
            logic [31:0] t;
            id = int'($urandom_range(10, 28));
            t  = ($urandom_range(0, 3) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($signed(int'($urandom_range(0, 40)) - 20)) : $urandom;
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), id, t, 1'b0);
        end

        // Halt raised during ISSUE: the instruction completes, then no requests.
        do_instr(1, 1, 16, 32'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_req", 64'(imem_req), 64'(0));
            chk("halted_pc", 64'(pc), 64'(model_pc));
        end
        halt = 1'b0;
        tick();
        chk("unhalt_req", 64'(imem_req), 64'(1));
        chk("unhalt_addr", 64'(imem_addr), 64'(model_pc));

        // Reset mid-FETCH; a late ack after release must be ignored.
        reset = 1'b1;
        #1;
        chk("midrst_req", 64'(imem_req), 64'(0));
        chk("midrst_pc", 64'(pc), 64'(0));
        chk("midrst_cnt", 64'(taken_cnt), 64'(0));
        model_pc  = 0;
        model_cnt = 0;
        tick();
        reset    = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_ignored", 64'(ir_valid), 64'(0));
        chk("refetch_req", 64'(imem_req), 64'(1));
        do_instr(0, 0, 21, 32'd55, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
